// File: rtl/operand_inject_queue_if.sv
// Operand channel bundle between an E-tile sender, the inject queue and the operand network
// switch. The slave modport is the queue's view; the master modport is its environment.
// Operand layout: [39:8] data, [7] valid, [6:0] source instruction.
interface operand_inject_queue_if;
  logic [39:0] in_operand;
  logic [6:0]  in_dest_instr;
  logic [1:0]  in_dest_slot;
  logic        in_req;
  logic        in_ack;
  logic [39:0] out_operand;
  logic [6:0]  out_dest_instr;
  logic [1:0]  out_dest_slot;
  logic [4:0]  out_dir;
  logic        out_req;
  logic        out_ack;

  modport master (
    output in_operand, in_dest_instr, in_dest_slot, in_req, out_ack,
    input  in_ack, out_operand, out_dest_instr, out_dest_slot, out_dir, out_req
  );

  modport slave (
    input  in_operand, in_dest_instr, in_dest_slot, in_req, out_ack,
    output in_ack, out_operand, out_dest_instr, out_dest_slot, out_dir, out_req
  );
endinterface

// File: rtl/operand_inject_queue.sv
// Operand inject queue: buffers operands produced by an E-tile, computes the X-then-Y mesh hop
// for the head entry and offers it on a registered req/ack channel to the operand switch.
// Optional feature macro: OPQ_STALL_COUNT_EN adds a saturating 16-bit stall_cycles counter.
module operand_inject_queue #(
  parameter int unsigned ROW_ID    = 0,
  parameter int unsigned COL_ID    = 0,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned GRID_COLS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  operand_inject_queue_if.slave    bus,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     full
`ifdef OPQ_STALL_COUNT_EN
  ,
  output logic [15:0]              stall_cycles
`endif
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  typedef logic [6:0] instr_num_t;
  typedef struct packed {
    logic [31:0] data;
    logic        valid;
    instr_num_t  source_instr;
  } operand_t;

  typedef enum logic {StIdle, StSend} state_e;

  operand_t        mem_op         [DEPTH];
  instr_num_t      mem_dest_instr [DEPTH];
  logic [1:0]      mem_dest_slot  [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q, next_ptr;
  logic [CntW-1:0] cnt_q;
  state_e          state_q, state_d;
  logic            out_req_q, out_req_d;
  logic [4:0]      out_dir_q, out_dir_d;
  operand_t        out_op_q;
  instr_num_t      out_dest_instr_q;
  logic [1:0]      out_dest_slot_q;

  operand_t        in_op, head_op, next_op, ld_op;
  instr_num_t      ld_instr;
  logic [1:0]      ld_slot;
  logic            push, pop, load;

  // Dimension-ordered hop: resolve the column first, then the row, else deliver locally.
  function automatic logic [4:0] route_dir(instr_num_t di);
    int unsigned node, dc, dr;
    node = {28'd0, di[3:0]};
    dc   = node % GRID_COLS;
    dr   = node / GRID_COLS;
    if (dc > COL_ID)      return 5'b00010;
    else if (dc < COL_ID) return 5'b00001;
    else if (dr > ROW_ID) return 5'b00100;
    else if (dr < ROW_ID) return 5'b01000;
    else                  return 5'b10000;
  endfunction

  assign in_op    = bus.in_operand;
  assign full     = (cnt_q == CntW'(DEPTH));
  // Never write a full FIFO, even if the head pops this cycle.
  assign push     = bus.in_req && !full && !flush;
  assign next_ptr = rd_ptr_q + PtrW'(1);
  assign head_op  = mem_op[rd_ptr_q];
  assign next_op  = mem_op[next_ptr];

  assign bus.in_ack         = push;
  assign bus.out_req        = out_req_q;
  assign bus.out_dir        = out_dir_q;
  assign bus.out_operand    = out_op_q;
  assign bus.out_dest_instr = out_dest_instr_q;
  assign bus.out_dest_slot  = out_dest_slot_q;
  assign occupancy          = cnt_q;

  // Output-stage next state: drop invalid heads, load the next offer, pop on ack.
  always_comb begin
    state_d   = state_q;
    out_req_d = out_req_q;
    out_dir_d = out_dir_q;
    pop       = 1'b0;
    load      = 1'b0;
    ld_op     = head_op;
    ld_instr  = mem_dest_instr[rd_ptr_q];
    ld_slot   = mem_dest_slot[rd_ptr_q];
    if (flush) begin
      state_d   = StIdle;
      out_req_d = 1'b0;
      out_dir_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cnt_q != '0) begin
            if (head_op.valid) load = 1'b1;
            else               pop  = 1'b1;
          end else if (push && in_op.valid) begin
            // Empty queue: offer the incoming operand straight away; it is still written.
            load     = 1'b1;
            ld_op    = in_op;
            ld_instr = bus.in_dest_instr;
            ld_slot  = bus.in_dest_slot;
          end
        end
        StSend: begin
          if (bus.out_ack) begin
            pop = 1'b1;
            if (cnt_q > CntW'(1) && next_op.valid) begin
              load     = 1'b1;
              ld_op    = next_op;
              ld_instr = mem_dest_instr[next_ptr];
              ld_slot  = mem_dest_slot[next_ptr];
            end else begin
              state_d   = StIdle;
              out_req_d = 1'b0;
              out_dir_d = '0;
            end
          end
        end
        default: state_d = StIdle;
      endcase
      if (load) begin
        state_d   = StSend;
        out_req_d = 1'b1;
        out_dir_d = route_dir(ld_instr);
      end
    end
  end

  // FIFO storage; contents are qualified by the occupancy count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_op[wr_ptr_q]         <= in_op;
      mem_dest_instr[wr_ptr_q] <= bus.in_dest_instr;
      mem_dest_slot[wr_ptr_q]  <= bus.in_dest_slot;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= next_ptr;
      cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
    end
  end

  // Output-stage state and registered handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      out_req_q <= 1'b0;
      out_dir_q <= '0;
    end else begin
      state_q   <= state_d;
      out_req_q <= out_req_d;
      out_dir_q <= out_dir_d;
    end
  end

  // Output payload registers, held stable while the offer waits for ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_op_q         <= '0;
      out_dest_instr_q <= '0;
      out_dest_slot_q  <= '0;
    end else if (load) begin
      out_op_q         <= ld_op;
      out_dest_instr_q <= ld_instr;
      out_dest_slot_q  <= ld_slot;
    end
  end

`ifdef OPQ_STALL_COUNT_EN
  logic [15:0] stall_q;
  assign stall_cycles = stall_q;

  // Cumulative back-pressure counter; saturates, cleared only by flush or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (flush) begin
      stall_q <= '0;
    end else if (out_req_q && !bus.out_ack && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_operand_inject_queue.sv
// Directed bench for operand_inject_queue at tile (1,1) of a 4-column grid, DEPTH 4.
module tb_operand_inject_queue;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [2:0] occupancy;
  logic       full;
`ifdef OPQ_STALL_COUNT_EN
  logic [15:0] stall_cycles;
`endif
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  operand_inject_queue_if intf ();

  operand_inject_queue #(
    .ROW_ID(1), .COL_ID(1), .DEPTH(4), .GRID_COLS(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus(intf),
    .occupancy(occupancy),
    .full(full)
`ifdef OPQ_STALL_COUNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] data, input logic valid, input logic [6:0] dest,
                       input logic [1:0] slot);
    intf.in_operand    = {data, valid, 7'h00};
    intf.in_dest_instr = dest;
    intf.in_dest_slot  = slot;
    intf.in_req        = 1'b1;
  endtask

  logic [6:0]  route_nodes [4];
  logic [4:0]  route_dirs  [3];
  logic [31:0] b2b_data    [3];

  initial begin
    route_nodes = '{7'd5, 7'd1, 7'd9, 7'd4};
    route_dirs  = '{5'b00100, 5'b00001, 5'b00010};
    b2b_data    = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
    rst_n = 1'b1;
    flush = 1'b0;
    intf.in_req = 1'b0;
    intf.out_ack = 1'b0;
    intf.in_operand = '0;
    intf.in_dest_instr = '0;
    intf.in_dest_slot = '0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_out_req", 64'(intf.out_req), 64'd0);
    check_eq("rst_out_dir", 64'(intf.out_dir), 64'd0);
    check_eq("rst_out_operand", 64'(intf.out_operand), 64'd0);
    check_eq("rst_out_dest", 64'({intf.out_dest_instr, intf.out_dest_slot}), 64'd0);
    check_eq("rst_occupancy", 64'(occupancy), 64'd0);
    check_eq("rst_full", 64'(full), 64'd0);
    check_eq("rst_in_ack", 64'(intf.in_ack), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single operand to node 11 (row 2, col 3): east hop, one cycle after accept.
    intf.out_ack = 1'b1;
    drive(32'hDEAD_BEEF, 1'b1, 7'h0B, 2'd1);
    #1;
    check_eq("t1_in_ack", 64'(intf.in_ack), 64'd1);
    check_eq("t1_req_before", 64'(intf.out_req), 64'd0);
    tick();
    intf.in_req = 1'b0;
    #1;
    check_eq("t1_out_req", 64'(intf.out_req), 64'd1);
    check_eq("t1_out_dir", 64'(intf.out_dir), 64'h02);
    check_eq("t1_data", 64'(intf.out_operand[39:8]), 64'hDEAD_BEEF);
    check_eq("t1_dest", 64'({intf.out_dest_instr, intf.out_dest_slot}), 64'({7'h0B, 2'd1}));
    check_eq("t1_occ_busy", 64'(occupancy), 64'd1);
    tick();
    check_eq("t1_req_after", 64'(intf.out_req), 64'd0);
    check_eq("t1_occ_after", 64'(occupancy), 64'd0);

    // Fill with nodes 5,1,9,4 under back-pressure; a fifth push must wait for a pop.
    intf.out_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(32'hA0 + 32'(i), 1'b1, route_nodes[i], 2'd0);
      #1;
      check_eq($sformatf("t2_in_ack%0d", i), 64'(intf.in_ack), 64'd1);
      tick();
    end
    drive(32'h55, 1'b1, 7'h0B, 2'd0);
    #1;
    check_eq("t2_fifth_blocked", 64'(intf.in_ack), 64'd0);
    check_eq("t2_full", 64'(full), 64'd1);
    check_eq("t2_occ4", 64'(occupancy), 64'd4);
    check_eq("t2_dir_local", 64'(intf.out_dir), 64'h10);
    intf.out_ack = 1'b1;
    #1;
    check_eq("t2_no_pass_through", 64'(intf.in_ack), 64'd0);
    tick();
    intf.out_ack = 1'b0;
    #1;
    check_eq("t2_dir_north", 64'(intf.out_dir), 64'h08);
    check_eq("t2_occ3", 64'(occupancy), 64'd3);
    check_eq("t2_fifth_accepted", 64'(intf.in_ack), 64'd1);
    tick();
    intf.in_req = 1'b0;
    intf.out_ack = 1'b1;
    #1;
    check_eq("t2_occ_refill", 64'(occupancy), 64'd4);
    check_eq("t2_dir_hold", 64'(intf.out_dir), 64'h08);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("t2_dir_seq%0d", i), 64'(intf.out_dir), 64'(route_dirs[i]));
      check_eq($sformatf("t2_occ_seq%0d", i), 64'(occupancy), 64'(3 - i));
    end
    check_eq("t2_fifth_data", 64'(intf.out_operand[39:8]), 64'h55);
    tick();
    check_eq("t2_drained_req", 64'(intf.out_req), 64'd0);
    check_eq("t2_drained_occ", 64'(occupancy), 64'd0);

    // Back-to-back: three queued entries leave on three consecutive cycles.
    intf.out_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(b2b_data[i], 1'b1, 7'd5, 2'd0);
      tick();
    end
    intf.in_req = 1'b0;
    intf.out_ack = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("t3_req%0d", i), 64'(intf.out_req), 64'd1);
      check_eq($sformatf("t3_data%0d", i), 64'(intf.out_operand[39:8]), 64'(b2b_data[i]));
      tick();
    end
    check_eq("t3_req_end", 64'(intf.out_req), 64'd0);

    // Flush with a coincident ack discards everything.
    intf.out_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'hF0 + 32'(i), 1'b1, 7'd9, 2'd1);
      tick();
    end
    drive(32'hFF, 1'b1, 7'd9, 2'd1);
    flush = 1'b1;
    intf.out_ack = 1'b1;
    #1;
    check_eq("t4_in_ack_flush", 64'(intf.in_ack), 64'd0);
    check_eq("t4_req_pre", 64'(intf.out_req), 64'd1);
    tick();
    flush = 1'b0;
    intf.in_req = 1'b0;
    #1;
    check_eq("t4_occ", 64'(occupancy), 64'd0);
    check_eq("t4_req", 64'(intf.out_req), 64'd0);
    check_eq("t4_full", 64'(full), 64'd0);
`ifdef OPQ_STALL_COUNT_EN
    check_eq("t4_stall_clear", 64'(stall_cycles), 64'd0);
`endif
    tick();
    check_eq("t4_req_later", 64'(intf.out_req), 64'd0);
    check_eq("t4_occ_later", 64'(occupancy), 64'd0);

    // Invalid operand is dropped at the head; only the valid one is offered.
    intf.out_ack = 1'b0;
    drive(32'h1111, 1'b0, 7'd5, 2'd0);
    tick();
    drive(32'h2222, 1'b1, 7'd1, 2'd2);
    #1;
    check_eq("t5_req_invalid", 64'(intf.out_req), 64'd0);
    tick();
    intf.in_req = 1'b0;
    #1;
    check_eq("t5_req_drop", 64'(intf.out_req), 64'd0);
    check_eq("t5_occ_drop", 64'(occupancy), 64'd1);
    tick();
    check_eq("t5_req", 64'(intf.out_req), 64'd1);
    check_eq("t5_data", 64'(intf.out_operand[39:8]), 64'h2222);
    check_eq("t5_dir", 64'(intf.out_dir), 64'h08);
    check_eq("t5_slot", 64'(intf.out_dest_slot), 64'd2);
`ifdef OPQ_STALL_COUNT_EN
    check_eq("t5_stall0", 64'(stall_cycles), 64'd0);
`endif
    repeat (10) tick();
`ifdef OPQ_STALL_COUNT_EN
    check_eq("t5_stall10", 64'(stall_cycles), 64'd10);
`endif
    check_eq("t5_data_held", 64'(intf.out_operand[39:8]), 64'h2222);
    intf.out_ack = 1'b1;
    tick();
    intf.out_ack = 1'b0;
    #1;
    check_eq("t5_req_done", 64'(intf.out_req), 64'd0);
    check_eq("t5_occ_done", 64'(occupancy), 64'd0);

    // Asynchronous reset in the middle of a transfer.
    drive(32'h7777, 1'b1, 7'd5, 2'd0);
    tick();
    tick();
    intf.in_req = 1'b0;
    #1;
    check_eq("t6_req_pre", 64'(intf.out_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_req_rst", 64'(intf.out_req), 64'd0);
    check_eq("t6_occ_rst", 64'(occupancy), 64'd0);
    check_eq("t6_dir_rst", 64'(intf.out_dir), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("t6_req_post", 64'(intf.out_req), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
